// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state enum, command byte codes, configuration reset values.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONF    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;

  // Power-on timing configuration, register i at bits [8i+7:8i].
  localparam int                      CONF_RST_N = 4;
  localparam logic [8*CONF_RST_N-1:0] CONF_RST   = 32'h0A14_3264;

  // Reset value of configuration register i; registers beyond the table reset to 0.
  function automatic logic [7:0] conf_rst_byte(input int i);
    if (i < CONF_RST_N) begin
      return CONF_RST[8*i +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: byte input stream plus pixel RAM / configuration outputs of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; byte_rdy_in is a one-cycle strobe with no ready return.
// Modports: slave = sequencer side (consumes bytes, drives RAM/conf/frame outputs),
//   master = surrounding logic (drives bytes, observes outputs).
interface spi_cmd_ctrl_if #(
  parameter int RAM_AW = 8,
  parameter int CONF_N = 4
);

  logic                 byte_rdy_in;
  logic [7:0]           byte_data_in;
  logic                 ram_wr_en_out;
  logic [RAM_AW-1:0]    ram_wr_addr_out;
  logic [7:0]           ram_wr_data_out;
  logic [CONF_N*8-1:0]  conf_data_out;
  logic                 frame_rdy_out;

  modport slave (
    input  byte_rdy_in,
    input  byte_data_in,
    output ram_wr_en_out,
    output ram_wr_addr_out,
    output ram_wr_data_out,
    output conf_data_out,
    output frame_rdy_out
  );

  modport master (
    output byte_rdy_in,
    output byte_data_in,
    input  ram_wr_en_out,
    input  ram_wr_addr_out,
    input  ram_wr_data_out,
    input  conf_data_out,
    input  frame_rdy_out
  );

endinterface

// File: rtl/cs_sync.sv
// cs_sync: 2-flop synchronizer for the raw SPI chip select with rising-edge (end of frame) detect.
// Latency: cs_end asserts 2-3 clk_in cycles after the spi chip select rising edge.
// Backpressure: none.
// Ports: clk_in, rst_n_in (async active-low), cs_n_in (raw, asynchronous);
//   cs_end (one-cycle pulse), cs_idle (chip select considered deasserted, bytes ignored).
module cs_sync (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic cs_n_in,
  output logic cs_end,
  output logic cs_idle
);

  logic meta_q;
  logic sync_q;
  logic sync_d1_q;

  // Reset to 1 so a chip select that is already deasserted never looks like an edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      sync_d1_q <= 1'b1;
    end else begin
      meta_q    <= cs_n_in;
      sync_q    <= meta_q;
      sync_d1_q <= sync_q;
    end
  end

  assign cs_end  = sync_q & ~sync_d1_q;
  // The cs_end cycle still counts as inside the frame so a coincident byte is processed.
  assign cs_idle = sync_q & sync_d1_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes the first byte of each SPI chip-select frame as a command and routes the
//   remaining bytes to the pixel RAM write port or the timing configuration registers.
// Latency: byte strobe in cycle n -> RAM write / conf update in n+1; frame_rdy_out the cycle after cs_end.
// Backpressure: none; a byte strobe is accepted on every cycle.
// Ports: clk_in, rst_n_in (async active-low), spi_cs_n_in (raw, asynchronous to clk_in);
//   bus (spi_cmd_ctrl_if.slave): byte_rdy_in/byte_data_in in; ram_wr_en/addr/data_out,
//   conf_data_out, frame_rdy_out out.
// Option: define CMD_TIMEOUT_EN to abort frames that see no byte for TIMEOUT_CYCLES cycles.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int RAM_AW         = 8,
  parameter int CONF_N         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            spi_cs_n_in,
  spi_cmd_ctrl_if.slave   bus
);

  localparam int IDXW = $clog2(CONF_N + 1);

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;      // next RAM address to write
  logic [IDXW-1:0]     idx_q, idx_d;        // next conf register, saturates at CONF_N
  logic                written_q, written_d;
  logic                ram_we_d;
  logic                conf_we;
  logic                frame_rdy_d;

  logic                cs_end;
  logic                cs_idle;
  logic                byte_act;
  logic                timeout_hit;

  logic                ram_wr_en_q;
  logic [RAM_AW-1:0]   ram_wr_addr_q;
  logic [7:0]          ram_wr_data_q;
  logic                frame_rdy_q;
  logic [7:0]          conf_q [CONF_N];

  cs_sync u_cs_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .cs_n_in  (spi_cs_n_in),
    .cs_end   (cs_end),
    .cs_idle  (cs_idle)
  );

  // Strobes arriving outside a chip-select frame are dropped.
  assign byte_act = bus.byte_rdy_in & ~cs_idle;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_IDLE || byte_act) begin
      to_cnt_q <= '0;
    end else if (!timeout_hit) begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      written_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      written_q <= written_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    written_d   = written_q;
    ram_we_d    = 1'b0;
    conf_we     = 1'b0;
    frame_rdy_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_act) begin
          case (bus.byte_data_in)
            CMD_CONF_WR: begin
              state_d = ST_CONF;
              idx_d   = '0;
            end
            CMD_DATA_WR: begin
              state_d   = ST_DATA;
              addr_d    = '0;
              written_d = 1'b0;
            end
            CMD_NOP: state_d = ST_IDLE;
            default: state_d = ST_DISCARD;
          endcase
        end
      end
      ST_CONF: begin
        if (byte_act && idx_q < IDXW'(CONF_N)) begin
          conf_we = 1'b1;
          idx_d   = idx_q + IDXW'(1);
        end
      end
      ST_DATA: begin
        if (byte_act) begin
          ram_we_d  = 1'b1;
          addr_d    = addr_q + RAM_AW'(1);   // wraps naturally at 2^RAM_AW
          written_d = 1'b1;
        end
      end
      ST_DISCARD: state_d = ST_DISCARD;
      default:    state_d = ST_IDLE;
    endcase

    // The coincident byte has already been handled above; only a DATA frame that
    // wrote at least one byte (possibly this cycle) announces a new frame.
    if (cs_end) begin
      frame_rdy_d = (state_q == ST_DATA) && written_d;
      state_d     = ST_IDLE;
    end

    // An aborted frame is never announced to the refresh logic.
    if (timeout_hit) begin
      frame_rdy_d = 1'b0;
      state_d     = ST_IDLE;
    end

    if (state_d == ST_IDLE) begin
      idx_d     = '0;
      written_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      frame_rdy_q   <= 1'b0;
    end else begin
      ram_wr_en_q <= ram_we_d;
      frame_rdy_q <= frame_rdy_d;
      if (ram_we_d) begin
        ram_wr_addr_q <= addr_q;
        ram_wr_data_q <= bus.byte_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < CONF_N; i++) begin
        conf_q[i] <= conf_rst_byte(i);
      end
    end else if (conf_we) begin
      for (int i = 0; i < CONF_N; i++) begin
        if (idx_q == IDXW'(i)) begin
          conf_q[i] <= bus.byte_data_in;
        end
      end
    end
  end

  assign bus.ram_wr_en_out   = ram_wr_en_q;
  assign bus.ram_wr_addr_out = ram_wr_addr_q;
  assign bus.ram_wr_data_out = ram_wr_data_q;
  assign bus.frame_rdy_out   = frame_rdy_q;

  for (genvar g = 0; g < CONF_N; g++) begin : g_conf_out
    assign bus.conf_data_out[8*g +: 8] = conf_q[g];
  end

endmodule
